// File: rtl/hazard_ctrl.sv
// Hazard, forwarding and pipeline-occupancy controller for the F/D/E/M/W core.
// Drives every stall, flush and forward-select of the datapath; tracks stage valids.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter bit FWD_EN         = 1'b1,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic                      RegWriteE,
  input  logic                      ResultSrcE0,
  input  logic                      PCSrcE,
  input  logic                      ExBusyE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic                      RegWriteM,
  input  logic                      MemReqM,
  input  logic                      MemReadyM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteW,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushM,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      ValidD,
  output logic                      ValidE,
  output logic                      ValidM,
  output logic                      ValidW,
  output logic [CNT_WIDTH-1:0]      StallCnt,
  output logic [CNT_WIDTH-1:0]      FlushCnt
);

  localparam logic [REG_ADDR_WIDTH-1:0] X0 = '0;

  logic prodE;
  logic prodM;
  logic prodW;
  logic hitED;
  logic hitMD;
  logic memWait;
  logic exWait;
  logic lwStall;
  logic rawStall;
  logic selMem;
  logic selEx;
  logic selBr;
  logic selLd;

  // Bubbles carry stale Rd fields, so every producer is gated by its valid.
  assign prodE = ValidE & RegWriteE & (RdE != X0);
  assign prodM = ValidM & RegWriteM & (RdM != X0);
  assign prodW = ValidW & RegWriteW & (RdW != X0);

  assign hitED = prodE & ((RdE == Rs1D) | (RdE == Rs2D));
  assign hitMD = prodM & ((RdM == Rs1D) | (RdM == Rs2D));

  assign memWait = ValidM & MemReqM & ~MemReadyM;
  assign exWait  = ValidE & ExBusyE;
  assign lwStall = hitED & ResultSrcE0 & ValidD;

  generate
    if (FWD_EN) begin : gRawOff
      assign rawStall = 1'b0;
    end else begin : gRawOn
      assign rawStall = ValidD & (hitED | hitMD);
    end
  endgenerate

  assign selMem = memWait;
  assign selEx  = ~memWait & exWait;
  assign selBr  = ~memWait & ~exWait & PCSrcE;
  assign selLd  = ~memWait & ~exWait & ~PCSrcE
                & (lwStall | rawStall);

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    FlushW = 1'b0;
    unique case (1'b1)
      selMem: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end
      selEx: begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end
      selBr: begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end
      selLd: begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
      default: begin
        StallF = 1'b0;
      end
    endcase
  end

  generate
    if (FWD_EN) begin : gFwd
      always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (prodM && (RdM == Rs1E)) begin
          ForwardAE = 2'b10;
        end else if (prodW && (RdW == Rs1E)) begin
          ForwardAE = 2'b01;
        end
        if (prodM && (RdM == Rs2E)) begin
          ForwardBE = 2'b10;
        end else if (prodW && (RdW == Rs2E)) begin
          ForwardBE = 2'b01;
        end
      end
    end else begin : gNoFwd
      assign ForwardAE = 2'b00;
      assign ForwardBE = 2'b00;
    end
  endgenerate

  // Fetch always supplies a real instruction, so D refills with 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      ValidD <= 1'b0;
      ValidE <= 1'b0;
      ValidM <= 1'b0;
      ValidW <= 1'b0;
    end else begin
      ValidD <= FlushD ? 1'b0 : (StallD ? ValidD : 1'b1);
      ValidE <= FlushE ? 1'b0 : (StallE ? ValidE : ValidD);
      ValidM <= FlushM ? 1'b0 : (StallM ? ValidM : ValidE);
      ValidW <= FlushW ? 1'b0 : ValidM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (StallF && (StallCnt != '1)) begin
        StallCnt <= StallCnt + 1'b1;
      end
      if (FlushD && (FlushCnt != '1)) begin
        FlushCnt <= FlushCnt + 1'b1;
      end
    end
  end

endmodule
